// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and helpers for the IF/DM memory port arbiter.
//            Holds the owner and FSM state enumerations and the helper that
//            sizes the memory latency down-counter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Width needed to hold the values 0..lat
    function automatic int latCntWidth(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

    localparam int DEFAULT_MEM_LAT = 2;
    localparam int LAT_CNT_W       = latCntWidth(DEFAULT_MEM_LAT);

endpackage
`default_nettype wire

// File: rtl/mem_arb_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_lat_cnt
// Purpose  : Loadable down-counter timing the memory latency of one access.
// Ports    : clk        clock, rising edge
//            rst_n      asynchronous reset, active low
//            i_load     load i_loadVal (has priority over i_dec)
//            i_loadVal  value to load
//            i_dec      decrement by one, holds at zero
//            o_done     count currently equals one (last wait cycle)
// Revision : 1.0  initial release
// ============================================================================
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = LAT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadVal,
    input  logic             i_dec,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between instruction fetch (IF)
//            and the MEM stage (DM). Each access runs IDLE->ISSUE->WAIT->DONE
//            through a fixed-latency memory; DM has priority in IDLE.
// Ports    : clk, rst_n                 clock / async active-low reset
//            if_req, if_addr            fetch request (held until if_valid)
//            if_rdata, if_valid         fetch data and completion pulse
//            dm_req, dm_we, dm_be,
//            dm_addr, dm_wdata          data request (held until dm_valid)
//            dm_rdata, dm_valid         read data (0 on write) and pulse
//            mem_req, mem_we, mem_be,
//            mem_addr, mem_wdata        registered access to memory
//            mem_rdata                  memory data, MEM_LAT after mem_req
//            stall_if, stall_dm         request pending and not completing
// Config   : ARB_ANTI_STARVE_EN - after STARVE_MAX DM grants made while IF
//            was waiting, the next IDLE arbitration favours IF.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
    output logic            stall_dm
);

    localparam int               CNT_W    = latCntWidth(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e            r_state;
    state_e            w_stateNext;
    owner_e            r_owner;
    logic [AW-1:0]     r_addr;
    logic              r_we;
    logic [DW/8-1:0]   r_be;
    logic [DW-1:0]     r_wdata;

    logic              w_forceIf;
    logic              w_grantDm;
    logic              w_grantIf;
    logic              w_cntLoad;
    logic              w_cntDec;
    logic              w_cntDone;
    logic              w_done;

    // ------------------------------------------------------------------
    // Arbitration (IDLE only, no preemption)
    // ------------------------------------------------------------------
    assign w_grantDm = (r_state == S_IDLE) && dm_req && !w_forceIf;
    assign w_grantIf = (r_state == S_IDLE) && if_req && !w_grantDm;

`ifdef ARB_ANTI_STARVE_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] r_starveCnt;

    // Counts DM grants that left IF waiting; an IF grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starveCnt <= '0;
        end else if (w_grantIf) begin
            r_starveCnt <= '0;
        end else if (w_grantDm && if_req && (r_starveCnt != SC_W'(STARVE_MAX))) begin
            r_starveCnt <= r_starveCnt + SC_W'(1);
        end
    end

    assign w_forceIf = if_req && (r_starveCnt == SC_W'(STARVE_MAX));
`else
    // Strict DM priority. STARVE_MAX is a non-negative count, so this
    // override is permanently low in this build.
    assign w_forceIf = (STARVE_MAX < 0);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntLoad   = 1'b0;
        w_cntDec    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grantDm || w_grantIf) begin
                    w_stateNext = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Counter covers the remaining MEM_LAT-1 wait cycles.
                w_cntLoad   = 1'b1;
                w_stateNext = (MEM_LAT == 1) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                w_cntDec = 1'b1;
                if (w_cntDone) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    mem_arb_lat_cnt #(
        .WIDTH (CNT_W)
    ) u_latCnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_cntLoad),
        .i_loadVal (CNT_LOAD),
        .i_dec     (w_cntDec),
        .o_done    (w_cntDone)
    );

    // ------------------------------------------------------------------
    // Latched access fields; fetches are always full-word reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_grantDm) begin
            r_owner <= OWN_DM;
            r_addr  <= dm_addr;
            r_we    <= dm_we;
            r_be    <= dm_be;
            r_wdata <= dm_wdata;
        end else if (w_grantIf) begin
            r_owner <= OWN_IF;
            r_addr  <= if_addr;
            r_we    <= 1'b0;
            r_be    <= '1;
            r_wdata <= '0;
        end else if (r_state == S_DONE) begin
            r_owner <= OWN_NONE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_done    = (r_state == S_DONE);
    assign if_valid  = w_done && (r_owner == OWN_IF);
    assign dm_valid  = w_done && (r_owner == OWN_DM);
    assign if_rdata  = (if_valid && !r_we) ? mem_rdata : '0;
    assign dm_rdata  = (dm_valid && !r_we) ? mem_rdata : '0;

    assign mem_req   = (r_state == S_ISSUE);
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign stall_if  = if_req && !if_valid;
    assign stall_dm  = dm_req && !dm_valid;

endmodule
`default_nettype wire
